// File: rtl/spi_lcd_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_lcd_rx_pkg
// Shared definitions for the ST7735-side SPI receiver: command opcodes,
// decoder state encoding, coordinate width and a saturating counter helper.
// -----------------------------------------------------------------------------
package spi_lcd_rx_pkg;

    localparam int COORD_W = 9;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CASET = 2'd1,
        ST_RASET = 2'd2,
        ST_RAMWR = 2'd3
    } dec_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/spi_lcd_rx_shift.sv
// -----------------------------------------------------------------------------
// spi_lcd_rx_shift
// Byte-level front end of the LCD link receiver. Synchronises the four bus
// wires into sys_clk, detects SPI mode-0 rising edges and reassembles
// MSB-first bytes tagged with the dc level seen at the 8th edge.
//
// Ports:
//   sys_clk_i    system clock
//   sys_rst_n_i  synchronous active-low reset
//   cs_i         chip select, active low (asynchronous to sys_clk)
//   dc_i         0 = command, 1 = data (asynchronous)
//   sclk_i       SPI clock, mode 0 (asynchronous)
//   mosi_i       serial data, MSB first (asynchronous)
//   rx_valid_o   one-cycle pulse: a complete byte is on rx_data_o
//   rx_data_o    {dc, byte}, held until the next rx_valid_o
//   frame_err_o  one-cycle pulse: cs was released with a partial byte
// -----------------------------------------------------------------------------
module spi_lcd_rx_shift
    import spi_lcd_rx_pkg::*;
(
    input  logic       sys_clk_i,
    input  logic       sys_rst_n_i,
    input  logic       cs_i,
    input  logic       dc_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    output logic       rx_valid_o,
    output logic [8:0] rx_data_o,
    output logic       frame_err_o
);

    // Synchroniser stages. sclk and cs carry a third stage for edge detection;
    // dc and mosi only need to stay aligned with sclk's second stage.
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic dc_s1_q, dc_s2_q;
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    logic       sclk_rise_s;
    logic       cs_rise_s;

    logic [6:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       rx_valid_q, rx_valid_d;
    logic [8:0] rx_data_q, rx_data_d;
    logic       frame_err_q, frame_err_d;

    // Two-flop synchronisers plus the extra edge-detect stages.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
            dc_s1_q   <= 1'b0;
            dc_s2_q   <= 1'b0;
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            cs_s1_q   <= cs_i;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            dc_s1_q   <= dc_i;
            dc_s2_q   <= dc_s1_q;
            sclk_s1_q <= sclk_i;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= mosi_i;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign sclk_rise_s = sclk_s2_q & ~sclk_s3_q;
    assign cs_rise_s   = cs_s2_q & ~cs_s3_q;

    // Shift/count next-state; a cs release takes priority and drops partial bits.
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        frame_err_d = 1'b0;
        if (cs_rise_s) begin
            shift_d     = 7'd0;
            cnt_d       = 3'd0;
            frame_err_d = (cnt_q != 3'd0);
        end else if (!cs_s2_q && sclk_rise_s) begin
            shift_d = {shift_q[5:0], mosi_s2_q};
            // 3'd7 + 1 wraps the counter back to zero on the 8th edge.
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                rx_valid_d = 1'b1;
                rx_data_d  = {dc_s2_q, shift_q, mosi_s2_q};
                shift_d    = 7'd0;
            end else begin
                rx_valid_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Shifter state and registered outputs.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            shift_q     <= 7'd0;
            cnt_q       <= 3'd0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 9'd0;
            frame_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_valid_o  = rx_valid_q;
    assign rx_data_o   = rx_data_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: rtl/spi_lcd_rx.sv
// -----------------------------------------------------------------------------
// spi_lcd_rx
// Display-side model of the ST7735 SPI link. Bytes from spi_lcd_rx_shift are
// decoded (CASET / RASET / RAMWR / SWRESET) into addressed RGB565 pixel writes
// that walk the current address window.
//
// Optional build macro: SPI_LCD_RX_STATS_EN adds saturating cmd_cnt/pix_cnt
// outputs (SWRESET clears pix_cnt only).
//
// Parameters:
//   COL_MAX  panel width  (reset window xe = COL_MAX-1)
//   ROW_MAX  panel height (reset window ye = ROW_MAX-1)
// Ports:
//   sys_clk, sys_rst_n             clock, synchronous active-low reset
//   lcd_cs, lcd_dc, lcd_sclk, lcd_mosi  4-wire SPI bus (mode 0)
//   rx_valid / rx_data             received byte pulse and {dc, byte}
//   pix_valid / pix_x / pix_y / pix_color  pixel write pulse and payload
//   win_done                       pulses with the pixel at (xe, ye)
//   frame_err                      cs released mid-byte
//   cmd_cnt, pix_cnt               statistics (SPI_LCD_RX_STATS_EN only)
// -----------------------------------------------------------------------------
module spi_lcd_rx
    import spi_lcd_rx_pkg::*;
#(
    parameter int COL_MAX = 128,
    parameter int ROW_MAX = 160
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               lcd_cs,
    input  logic               lcd_dc,
    input  logic               lcd_sclk,
    input  logic               lcd_mosi,
    output logic               rx_valid,
    output logic [8:0]         rx_data,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_color,
    output logic               win_done,
`ifdef SPI_LCD_RX_STATS_EN
    output logic [15:0]        cmd_cnt,
    output logic [15:0]        pix_cnt,
`endif
    output logic               frame_err
);

    localparam logic [COORD_W-1:0] XE_RST = COORD_W'(COL_MAX - 1);
    localparam logic [COORD_W-1:0] YE_RST = COORD_W'(ROW_MAX - 1);

    logic       rx_valid_s;
    logic [8:0] rx_data_s;
    logic [7:0] rx_byte_s;

    dec_state_e state_q, state_d;
    logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               phase_q, phase_d;     // 1 = hi pixel byte already held
    logic [7:0]         hi_q, hi_d;
    logic [1:0]         pcnt_q, pcnt_d;       // CASET/RASET parameter index
    logic [COORD_W-1:0] start_q, start_d;
    logic               end_hi_q, end_hi_d;   // bit 8 of the window end value
    logic               pix_valid_q, pix_valid_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0]        pix_color_q, pix_color_d;
    logic               win_done_q, win_done_d;

    spi_lcd_rx_shift u_shift (
        .sys_clk_i   (sys_clk),
        .sys_rst_n_i (sys_rst_n),
        .cs_i        (lcd_cs),
        .dc_i        (lcd_dc),
        .sclk_i      (lcd_sclk),
        .mosi_i      (lcd_mosi),
        .rx_valid_o  (rx_valid_s),
        .rx_data_o   (rx_data_s),
        .frame_err_o (frame_err)
    );

    assign rx_byte_s = rx_data_s[7:0];

    // Decoder next-state: commands always win; data bytes act per state.
    always_comb begin
        state_d     = state_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        x_d         = x_q;
        y_d         = y_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        pcnt_d      = pcnt_q;
        start_d     = start_q;
        end_hi_d    = end_hi_q;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_color_d = pix_color_q;
        win_done_d  = 1'b0;
        if (rx_valid_s) begin
            if (!rx_data_s[8]) begin
                // Any command aborts pending parameters or half pixels.
                phase_d = 1'b0;
                pcnt_d  = 2'd0;
                case (rx_byte_s)
                    CMD_CASET: state_d = ST_CASET;
                    CMD_RASET: state_d = ST_RASET;
                    CMD_RAMWR: begin
                        state_d = ST_RAMWR;
                        x_d     = xs_q;
                        y_d     = ys_q;
                    end
                    CMD_SWRESET: begin
                        state_d = ST_IDLE;
                        xs_d    = 9'd0;
                        xe_d    = XE_RST;
                        ys_d    = 9'd0;
                        ye_d    = YE_RST;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        pcnt_d = pcnt_q + 2'd1;
                        case (pcnt_q)
                            2'd0: start_d[8]   = rx_byte_s[0];
                            2'd1: start_d[7:0] = rx_byte_s;
                            2'd2: end_hi_d     = rx_byte_s[0];
                            2'd3: begin
                                state_d = ST_IDLE;
                                if (state_q == ST_CASET) begin
                                    xs_d = start_q;
                                    xe_d = {end_hi_q, rx_byte_s};
                                end else begin
                                    ys_d = start_q;
                                    ye_d = {end_hi_q, rx_byte_s};
                                end
                            end
                            default: pcnt_d = 2'd0;
                        endcase
                    end
                    ST_RAMWR: begin
                        if (!phase_q) begin
                            hi_d    = rx_byte_s;
                            phase_d = 1'b1;
                        end else begin
                            phase_d     = 1'b0;
                            pix_valid_d = 1'b1;
                            pix_x_d     = x_q;
                            pix_y_d     = y_q;
                            pix_color_d = {hi_q, rx_byte_s};
                            // Equality (not range) compares: an inverted
                            // window just snaps back to start every pixel.
                            if (x_q == xe_q) begin
                                x_d = xs_q;
                                if (y_q == ye_q) begin
                                    y_d        = ys_q;
                                    win_done_d = 1'b1;
                                end else begin
                                    y_d = y_q + 9'd1;
                                end
                            end else begin
                                x_d = x_q + 9'd1;
                            end
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end else begin
            pix_valid_d = 1'b0;
        end
    end

    // Decoder state, window, cursor and registered pixel outputs.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            xs_q        <= 9'd0;
            xe_q        <= XE_RST;
            ys_q        <= 9'd0;
            ye_q        <= YE_RST;
            x_q         <= 9'd0;
            y_q         <= 9'd0;
            phase_q     <= 1'b0;
            hi_q        <= 8'd0;
            pcnt_q      <= 2'd0;
            start_q     <= 9'd0;
            end_hi_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= 9'd0;
            pix_y_q     <= 9'd0;
            pix_color_q <= 16'd0;
            win_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            x_q         <= x_d;
            y_q         <= y_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            pcnt_q      <= pcnt_d;
            start_q     <= start_d;
            end_hi_q    <= end_hi_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_color_q <= pix_color_d;
            win_done_q  <= win_done_d;
        end
    end

`ifdef SPI_LCD_RX_STATS_EN
    logic        cmd_seen_s;
    logic        swreset_s;
    logic [15:0] cmd_cnt_q, cmd_cnt_d, pix_cnt_q, pix_cnt_d;

    assign cmd_seen_s = rx_valid_s & ~rx_data_s[8];
    assign swreset_s  = cmd_seen_s & (rx_byte_s == CMD_SWRESET);

    // Statistics next-state; pix_cnt follows the registered pix_valid pulse.
    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        pix_cnt_d = pix_cnt_q;
        if (cmd_seen_s) begin
            cmd_cnt_d = sat_inc16(cmd_cnt_q);
        end else begin
            cmd_cnt_d = cmd_cnt_q;
        end
        if (swreset_s) begin
            pix_cnt_d = 16'd0;
        end else if (pix_valid_q) begin
            pix_cnt_d = sat_inc16(pix_cnt_q);
        end else begin
            pix_cnt_d = pix_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cmd_cnt_q <= 16'd0;
            pix_cnt_q <= 16'd0;
        end else begin
            cmd_cnt_q <= cmd_cnt_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    assign cmd_cnt = cmd_cnt_q;
    assign pix_cnt = pix_cnt_q;
`endif

    assign rx_valid  = rx_valid_s;
    assign rx_data   = rx_data_s;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_color = pix_color_q;
    assign win_done  = win_done_q;

endmodule

// File: tb/tb_spi_lcd_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_lcd_rx
// Scoreboard bench: a bit-banged writer (HALFDIV = 2) drives the SPI bus and
// pushes expected bytes/pixels into queues; a monitor pops and compares them
// whenever rx_valid / pix_valid pulse. A reduced panel (8x6) keeps the
// full-window RAMWR walk short.
// -----------------------------------------------------------------------------
module tb_spi_lcd_rx;
    import spi_lcd_rx_pkg::*;

    localparam int COLS = 8;
    localparam int ROWS = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        dc = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        rx_valid;
    logic [8:0]  rx_data;
    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_color;
    logic        win_done;
    logic        frame_err;
`ifdef SPI_LCD_RX_STATS_EN
    logic [15:0] cmd_cnt;
    logic [15:0] pix_cnt;
`endif

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] c;
        logic        wd;
    } pix_t;

    logic [8:0] rx_exp_q[$];
    pix_t       pix_exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         fe_count = 0;

    always #5 clk = ~clk;

    spi_lcd_rx #(.COL_MAX(COLS), .ROW_MAX(ROWS)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .lcd_cs    (cs),
        .lcd_dc    (dc),
        .lcd_sclk  (sclk),
        .lcd_mosi  (mosi),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .win_done  (win_done),
`ifdef SPI_LCD_RX_STATS_EN
        .cmd_cnt   (cmd_cnt),
        .pix_cnt   (pix_cnt),
`endif
        .frame_err (frame_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                if (rx_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else begin
                    check("rx_data", 64'(rx_data), 64'(rx_exp_q.pop_front()));
                end
            end
            if (pix_valid) begin
                if (pix_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_unexpected: got x=%0d y=%0d c=%0h wd=%0b expected none",
                             pix_x, pix_y, pix_color, win_done);
                end else begin
                    check("pixel", 64'({pix_x, pix_y, pix_color, win_done}),
                          64'(pix_exp_q.pop_front()));
                end
            end
            if (win_done && !pix_valid) begin
                checks++;
                errors++;
                $display("FAIL win_done_alone: got 1 expected 0");
            end
            if (frame_err) fe_count++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            sclk = 1'b0;
            wait_cyc(2);
            sclk = 1'b1;
            wait_cyc(2);
        end
        sclk = 1'b0;
        wait_cyc(2);
    endtask

    task automatic send_byte(input logic d, input logic [7:0] b);
        rx_exp_q.push_back({d, b});
        if (cs) begin
            cs = 1'b0;
            wait_cyc(2);
        end
        dc = d;
        shift_bits(b, 8);
        wait_cyc(1);
    endtask

    task automatic send_pix(input logic [15:0] c);
        send_byte(1'b1, c[15:8]);
        send_byte(1'b1, c[7:0]);
    endtask

    task automatic expect_pix(input int x, input int y, input logic [15:0] c, input logic wd);
        pix_exp_q.push_back('{x: 9'(x), y: 9'(y), c: c, wd: wd});
    endtask

    task automatic release_cs();
        cs = 1'b1;
        wait_cyc(6);
    endtask

    // Bounded wait for the scoreboard queues to empty.
    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (rx_exp_q.size() == 0 && pix_exp_q.size() == 0) break;
            wait_cyc(1);
        end
        check({name, "_rx_left"}, 64'(rx_exp_q.size()), 64'd0);
        check({name, "_pix_left"}, 64'(pix_exp_q.size()), 64'd0);
        rx_exp_q.delete();
        pix_exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_rx_valid"}, 64'(rx_valid), 64'd0);
        check({name, "_rx_data"}, 64'(rx_data), 64'd0);
        check({name, "_pix_valid"}, 64'(pix_valid), 64'd0);
        check({name, "_pix_x"}, 64'(pix_x), 64'd0);
        check({name, "_pix_y"}, 64'(pix_y), 64'd0);
        check({name, "_pix_color"}, 64'(pix_color), 64'd0);
        check({name, "_win_done"}, 64'(win_done), 64'd0);
        check({name, "_frame_err"}, 64'(frame_err), 64'd0);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        wait_cyc(4);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        wait_cyc(4);

        // Partial byte: 5 bits then cs release -> one frame_err, no rx_valid
        cs = 1'b0;
        wait_cyc(2);
        shift_bits(8'hA5, 5);
        release_cs();
        check("frame_err_count", 64'(fe_count), 64'd1);
        send_byte(1'b1, 8'h55);     // ignored by the IDLE decoder
        drain("after_frame");
        release_cs();

        // RAMWR at the reset window origin
        send_byte(1'b0, CMD_RAMWR);
        expect_pix(0, 0, 16'hF800, 1'b0);
        send_pix(16'hF800);
        drain("first_pixel");

        // Lone CASET command: one rx_valid, no pixel
        send_byte(1'b0, CMD_CASET);
        drain("caset_cmd");
        release_cs();

        // 2x1 window at columns 2..3, row 5
        send_byte(1'b0, CMD_CASET);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h02);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h03);
        send_byte(1'b0, CMD_RASET);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        release_cs();               // RAMWR context is kept across cs toggles
        send_byte(1'b0, CMD_RAMWR);
        expect_pix(2, 5, 16'hF800, 1'b0);
        send_pix(16'hF800);
        release_cs();
        expect_pix(3, 5, 16'h07E0, 1'b1);
        send_pix(16'h07E0);
        expect_pix(2, 5, 16'hAA55, 1'b0);
        send_pix(16'hAA55);
        drain("window");
        check("frame_err_count_silent", 64'(fe_count), 64'd1);

        // Half pixel aborted by a command; window columns stay 2..3
        send_byte(1'b0, CMD_RAMWR);
        send_byte(1'b1, 8'h12);
        send_byte(1'b0, CMD_RASET);
        drain("abort");
        check("state_raset", 64'(dut.state_q), 64'(ST_RASET));
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h01);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h04);
        send_byte(1'b0, CMD_RAMWR);
        expect_pix(2, 1, 16'hABCD, 1'b0);
        send_pix(16'hABCD);
        expect_pix(3, 1, 16'h1234, 1'b0);
        send_pix(16'h1234);
        expect_pix(2, 2, 16'h5678, 1'b0);
        send_pix(16'h5678);
        drain("after_abort");

        // SWRESET then a full-panel RAMWR: one win_done on the last pixel
        send_byte(1'b0, CMD_SWRESET);
        send_byte(1'b0, CMD_RAMWR);
        for (int i = 0; i < COLS * ROWS; i++) begin
            logic [15:0] c;
            c = {8'(i), ~8'(i)};
            expect_pix(i % COLS, i / COLS, c, (i == COLS * ROWS - 1) ? 1'b1 : 1'b0);
            send_pix(c);
        end
        drain("full_panel");
        release_cs();

        // Reset mid-byte: partial bits discarded, no pulses, outputs cleared
        cs = 1'b0;
        wait_cyc(2);
        shift_bits(8'hFF, 3);
        rst_n = 1'b0;
        wait_cyc(3);
        check_outputs_zero("mid_reset");
        rst_n = 1'b1;
        release_cs();
        check("frame_err_after_reset", 64'(fe_count), 64'd1);
        send_byte(1'b0, CMD_CASET);
        drain("post_reset");
        release_cs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
